channel_link_tx_buf: RTL and testbench

Parametrised DAQ channel-link transmitter that buffers frame words from the DCFEB readout path in a small FIFO and drains them to the motherboard link only while the link reports ready. It drives the push strobe, data-available, end-word and overlap sideband signals. It adds a configurable DAV delay, overflow detection and frame counting. It sits between the frame assembler and the board-level output buffers.

---
 rtl/channel_link_tx_buf.sv | 82 ++++++++
 tb/tb_channel_link_tx_buf.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/channel_link_tx_buf.sv
// channel_link_tx_buf: FIFO-buffered DAQ channel-link transmitter draining words while LINK_RDY,
// with delayed DATAAVAIL, sticky overflow flag and end-word frame counter.
module channel_link_tx_buf #(
    parameter int DW      = 16,
    parameter int DEPTH   = 16,
    parameter int DAV_DLY = 1,
    parameter int CNT_W   = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DW-1:0]            FRAME_DATA,
    input  logic                     DVALID,
    input  logic                     LAST_WRD,
    input  logic                     OVLP_MUX,
    input  logic                     MLT_OVLP,
    input  logic                     L1A_MATCH,
    input  logic                     LINK_RDY,
    output logic [DW-1:0]            DATAOUT,
    output logic                     MB_FIFO_PUSH_B,
    output logic                     ENDWORD,
    output logic                     OVLPMUX,
    output logic                     MOVLP,
    output logic                     DATAAVAIL,
    output logic                     FIFO_FULL,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVERFLOW,
    output logic [CNT_W-1:0]         FRAME_CNT
);
    localparam int AW = $clog2(DEPTH);

    logic [DW+2:0]      mem [DEPTH];
    logic [AW-1:0]      wp, rp;
    logic [DAV_DLY-1:0] dav_sr;
    logic               pop, wr;
    logic [AW:0]        level_nxt;
    logic [DW+2:0]      ent;

    // Pop looks only at registered occupancy, so a word needs one edge in the FIFO before it can leave.
    always_comb begin
        pop       = (LEVEL != '0) && LINK_RDY;
        wr        = DVALID && (!FIFO_FULL || pop);
        level_nxt = (wr && !pop) ? LEVEL + 1'b1 : (pop && !wr) ? LEVEL - 1'b1 : LEVEL;
        ent       = mem[rp];
    end

    always_ff @(posedge CLK)
        if (wr) mem[wp] <= {MLT_OVLP, OVLP_MUX, LAST_WRD, FRAME_DATA};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp             <= '0;
            rp             <= '0;
            LEVEL          <= '0;
            FIFO_FULL      <= 1'b0;
            OVERFLOW       <= 1'b0;
            dav_sr         <= '0;
            MB_FIFO_PUSH_B <= 1'b1;
            ENDWORD        <= 1'b0;
            DATAOUT        <= '0;
            OVLPMUX        <= 1'b0;
            MOVLP          <= 1'b0;
            FRAME_CNT      <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            LEVEL          <= level_nxt;
            FIFO_FULL      <= level_nxt == (AW+1)'(DEPTH);
            if (DVALID && !wr) OVERFLOW <= 1'b1;
            dav_sr         <= (dav_sr << 1) | DAV_DLY'(L1A_MATCH);
            MB_FIFO_PUSH_B <= !pop;
            ENDWORD        <= pop && ent[DW];
            if (pop) begin
                DATAOUT   <= ent[DW-1:0];
                OVLPMUX   <= ent[DW+1];
                MOVLP     <= ent[DW+2];
                FRAME_CNT <= FRAME_CNT + CNT_W'(ent[DW]);
            end
        end
    end

    assign DATAAVAIL = dav_sr[DAV_DLY-1];
endmodule

// File: tb/tb_channel_link_tx_buf.sv
// tb_channel_link_tx_buf: random and directed stimulus checked against a queue-based
// behavioural model of the transmitter.
module tb_channel_link_tx_buf;
    localparam int DW = 16, DEPTH = 16, DAV_DLY = 3, CNT_W = 4;

    logic            CLK, RST;
    logic [DW-1:0]   FRAME_DATA;
    logic            DVALID, LAST_WRD, OVLP_MUX, MLT_OVLP, L1A_MATCH, LINK_RDY;
    logic [DW-1:0]   DATAOUT;
    logic            MB_FIFO_PUSH_B, ENDWORD, OVLPMUX, MOVLP, DATAAVAIL, FIFO_FULL, OVERFLOW;
    logic [4:0]      LEVEL;
    logic [CNT_W-1:0] FRAME_CNT;

    channel_link_tx_buf #(.DW(DW), .DEPTH(DEPTH), .DAV_DLY(DAV_DLY), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .FRAME_DATA(FRAME_DATA), .DVALID(DVALID), .LAST_WRD(LAST_WRD),
        .OVLP_MUX(OVLP_MUX), .MLT_OVLP(MLT_OVLP), .L1A_MATCH(L1A_MATCH), .LINK_RDY(LINK_RDY),
        .DATAOUT(DATAOUT), .MB_FIFO_PUSH_B(MB_FIFO_PUSH_B), .ENDWORD(ENDWORD), .OVLPMUX(OVLPMUX),
        .MOVLP(MOVLP), .DATAAVAIL(DATAAVAIL), .FIFO_FULL(FIFO_FULL), .LEVEL(LEVEL),
        .OVERFLOW(OVERFLOW), .FRAME_CNT(FRAME_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0;

    logic [DW+2:0]    q[$];
    logic             dq[$];
    logic [DW-1:0]    m_data;
    logic             m_push_b, m_end, m_ovm, m_mlt, m_ovf, m_dav;
    logic [CNT_W-1:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        dq.delete();
        for (int i = 0; i < DAV_DLY - 1; i++) dq.push_back(1'b0);
        m_data = '0; m_push_b = 1'b1; m_end = 0; m_ovm = 0; m_mlt = 0; m_ovf = 0; m_dav = 0; m_cnt = '0;
    endtask

    task automatic check_all();
        chk("dataout", 32'(DATAOUT), 32'(m_data));
        chk("push_b", 32'(MB_FIFO_PUSH_B), 32'(m_push_b));
        chk("endword", 32'(ENDWORD), 32'(m_end));
        chk("ovlpmux", 32'(OVLPMUX), 32'(m_ovm));
        chk("movlp", 32'(MOVLP), 32'(m_mlt));
        chk("dataavail", 32'(DATAAVAIL), 32'(m_dav));
        chk("level", 32'(LEVEL), 32'(q.size()));
        chk("fifo_full", 32'(FIFO_FULL), 32'(q.size() == DEPTH));
        chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
        chk("frame_cnt", 32'(FRAME_CNT), 32'(m_cnt));
    endtask

    task automatic step(input logic dv, input logic [DW-1:0] d, input logic last, input logic ovm,
                        input logic mlt, input logic l1a, input logic rdy);
        logic p, w;
        logic [DW+2:0] e;
        @(negedge CLK);
        DVALID = dv; FRAME_DATA = d; LAST_WRD = last; OVLP_MUX = ovm; MLT_OVLP = mlt;
        L1A_MATCH = l1a; LINK_RDY = rdy;
        p = (q.size() != 0) && rdy;
        w = dv && (q.size() < DEPTH || p);
        if (p) begin
            e = q.pop_front();
            m_data = e[DW-1:0]; m_end = e[DW]; m_ovm = e[DW+1]; m_mlt = e[DW+2]; m_push_b = 1'b0;
            if (e[DW]) m_cnt = m_cnt + 1'b1;
        end else begin
            m_push_b = 1'b1; m_end = 1'b0;
        end
        if (w) q.push_back({mlt, ovm, last, d});
        if (dv && !w) m_ovf = 1'b1;
        dq.push_back(l1a);
        m_dav = dq.pop_front();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic async_reset();
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge CLK);
        RST = 1'b0; DVALID = 0; L1A_MATCH = 0; LINK_RDY = 0;
    endtask

    logic [4:0] dav_seen;

    initial begin
        RST = 1'b1; DVALID = 0; FRAME_DATA = '0; LAST_WRD = 0; OVLP_MUX = 0; MLT_OVLP = 0;
        L1A_MATCH = 0; LINK_RDY = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 check_all();
        @(negedge CLK) RST = 1'b0;

        // 5-word streaming frame
        for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), i == 5, i[0], i[1], 1'b0, 1'b1);
        repeat (2) idle(1'b1);
        chk("frame_cnt_after_frame", 32'(FRAME_CNT), 32'd1);

        // backpressure to full, then overflow
        for (int i = 0; i < 16; i++) step(1'b1, DW'(16'h100 + i), i == 15, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("level_full", 32'(LEVEL), 32'd16);
        step(1'b1, 16'hdead, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("overflow_set", 32'(OVERFLOW), 32'd1);
        repeat (18) idle(1'b1);
        chk("overflow_sticky", 32'(OVERFLOW), 32'd1);

        // full with simultaneous write and pop
        for (int i = 0; i < 16; i++) step(1'b1, DW'(16'h200 + i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hbeef, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("level_full_wr_pop", 32'(LEVEL), 32'd16);
        repeat (17) idle(1'b1);

        // DAV pulse with FIFO traffic
        dav_seen = '0;
        step(1'b1, 16'h0abc, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        dav_seen[0] = DATAAVAIL;
        for (int i = 1; i < 5; i++) begin
            step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            dav_seen[i] = DATAAVAIL;
        end
        chk("dav_pulse", 32'(dav_seen), 32'b00100);

        // frame counter and pointer wrap
        for (int i = 0; i < 40; i++) step(1'b1, DW'(16'h300 + i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (20) idle(1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) == 0,
                 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
                 (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));

        // reset mid-frame discards buffered words
        for (int i = 0; i < 3; i++) step(1'b1, DW'(16'h400 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        async_reset();
        chk("push_b_in_reset", 32'(MB_FIFO_PUSH_B), 32'd1);
        repeat (4) idle(1'b1);
        chk("level_after_reset", 32'(LEVEL), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
